// File: rtl/tlp_tx_arb.sv
// Packet-atomic arbiter for the shared 64-bit PCIe TX Avalon-ST channel.
// One source owns the channel from SOP through EOP; beats pass with no added latency.
module tlp_tx_arb #(
    parameter int NUM_SRC   = 2,
    parameter bit PRIO_SRC0 = 1'b0,
    parameter int IDX_BITS  = $clog2(NUM_SRC)
) (
    input  logic                       pcieClk_in,
    input  logic                       pcieRstN_in,
    input  logic [NUM_SRC-1:0][63:0]   srcData_in,
    input  logic [NUM_SRC-1:0]         srcValid_in,
    output logic [NUM_SRC-1:0]         srcReady_out,
    input  logic [NUM_SRC-1:0]         srcSOP_in,
    input  logic [NUM_SRC-1:0]         srcEOP_in,
    output logic [63:0]                txData_out,
    output logic                       txValid_out,
    input  logic                       txReady_in,
    output logic                       txSOP_out,
    output logic                       txEOP_out,
    output logic [IDX_BITS-1:0]        grant_out,
    output logic                       busy_out,
    output logic                       protoErr_out
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_BITS-1:0] owner_q, owner_d;
    logic [IDX_BITS-1:0] last_q, last_d;
    logic                err_q, err_d;

    logic [NUM_SRC-1:0]  req;
    logic [NUM_SRC-1:0]  stray;
    logic                has_req;
    logic [IDX_BITS-1:0] arb_sel;
    logic [IDX_BITS-1:0] sel;
    logic                fwd;
    logic                accept;
    logic                found;
    int                  idx;

    assign req     = srcValid_in & srcSOP_in;
    assign stray   = srcValid_in & ~srcSOP_in;
    assign has_req = |req;

    // Round-robin scan starts just after the last granted source.
    always_comb begin
        arb_sel = last_q;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!found && req[idx]) begin
                arb_sel = IDX_BITS'(idx);
                found   = 1'b1;
            end
        end
        if (PRIO_SRC0 && req[0]) begin
            arb_sel = '0;
        end
    end

    assign sel    = (state_q == LOCKED) ? owner_q : arb_sel;
    assign fwd    = (state_q == LOCKED) || has_req;
    assign accept = fwd && srcValid_in[sel] && txReady_in;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        err_d        = err_q;
        txData_out   = '0;
        txValid_out  = 1'b0;
        txSOP_out    = 1'b0;
        txEOP_out    = 1'b0;
        srcReady_out = '0;
        grant_out    = last_q;

        if (fwd) begin
            txData_out        = srcData_in[sel];
            txValid_out       = srcValid_in[sel];
            txSOP_out         = srcSOP_in[sel];
            txEOP_out         = srcEOP_in[sel];
            srcReady_out[sel] = txReady_in;
            grant_out         = sel;
        end

        unique case (state_q)
            IDLE: begin
                // Mid-packet beats with no owner are drained and flagged.
                srcReady_out = srcReady_out | stray;
                if (|stray) begin
                    err_d = 1'b1;
                end
                if (accept) begin
                    last_d = sel;
                    if (!srcEOP_in[sel]) begin
                        owner_d = sel;
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (accept) begin
                    if (srcSOP_in[sel]) begin
                        err_d = 1'b1;
                    end
                    if (srcEOP_in[sel]) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
        if (!pcieRstN_in) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDX_BITS'(NUM_SRC - 1);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign busy_out     = (state_q == LOCKED);
    assign protoErr_out = err_q;

endmodule

// File: tb/tb_tlp_tx_arb.sv
// Directed bench for tlp_tx_arb: a 3-source round-robin instance
// and a 2-source instance with source-0 priority.
module tb_tlp_tx_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [2:0][63:0] a_data;
    logic [2:0]       a_valid, a_sop, a_eop, a_rdy;
    logic [63:0]      a_txd;
    logic             a_txv, a_txs, a_txe, a_txr, a_busy, a_err;
    logic [1:0]       a_gnt;

    logic [1:0][63:0] b_data;
    logic [1:0]       b_valid, b_sop, b_eop, b_rdy;
    logic [63:0]      b_txd;
    logic             b_txv, b_txs, b_txe, b_txr, b_busy, b_err;
    logic [0:0]       b_gnt;

    tlp_tx_arb #(.NUM_SRC(3), .PRIO_SRC0(1'b0)) u_a (
        .pcieClk_in(clk), .pcieRstN_in(rst_n),
        .srcData_in(a_data), .srcValid_in(a_valid), .srcReady_out(a_rdy),
        .srcSOP_in(a_sop), .srcEOP_in(a_eop),
        .txData_out(a_txd), .txValid_out(a_txv), .txReady_in(a_txr),
        .txSOP_out(a_txs), .txEOP_out(a_txe),
        .grant_out(a_gnt), .busy_out(a_busy), .protoErr_out(a_err)
    );

    tlp_tx_arb #(.NUM_SRC(2), .PRIO_SRC0(1'b1)) u_b (
        .pcieClk_in(clk), .pcieRstN_in(rst_n),
        .srcData_in(b_data), .srcValid_in(b_valid), .srcReady_out(b_rdy),
        .srcSOP_in(b_sop), .srcEOP_in(b_eop),
        .txData_out(b_txd), .txValid_out(b_txv), .txReady_in(b_txr),
        .txSOP_out(b_txs), .txEOP_out(b_txe),
        .grant_out(b_gnt), .busy_out(b_busy), .protoErr_out(b_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_a;
        a_valid = '0; a_sop = '0; a_eop = '0; a_data = '0;
    endtask

    task automatic clr_b;
        b_valid = '0; b_sop = '0; b_eop = '0; b_data = '0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clr_a(); clr_b();
        a_txr = 1'b0; b_txr = 1'b0;
        #12;
        checks++; if (a_txv !== 1'b0) begin failures++; $display("FAIL rst_txv got=%b exp=0", a_txv); end
        checks++; if (a_txd !== 64'h0) begin failures++; $display("FAIL rst_txd got=%h exp=0", a_txd); end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", a_busy); end
        checks++; if (a_gnt !== 2'd2) begin failures++; $display("FAIL rst_gnt got=%0d exp=2", a_gnt); end
        checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", a_err); end
        checks++; if (a_rdy !== 3'b000) begin failures++; $display("FAIL rst_rdy got=%b exp=000", a_rdy); end
        checks++; if (b_gnt !== 1'b1) begin failures++; $display("FAIL rst_b_gnt got=%0d exp=1", b_gnt); end
        rst_n = 1'b1;
        a_txr = 1'b1; b_txr = 1'b1;
    endtask

    task automatic test_single;
        tick();
        a_valid[1] = 1'b1; a_sop[1] = 1'b1; a_data[1] = 64'h1;
        #2;
        checks++; if (a_txv !== 1'b1) begin failures++; $display("FAIL single_v0 got=%b exp=1", a_txv); end
        checks++; if (a_txd !== 64'h1) begin failures++; $display("FAIL single_d0 got=%h exp=1", a_txd); end
        checks++; if (a_txs !== 1'b1 || a_txe !== 1'b0) begin failures++; $display("FAIL single_se0 got=%b%b exp=10", a_txs, a_txe); end
        checks++; if (a_gnt !== 2'd1) begin failures++; $display("FAIL single_gnt0 got=%0d exp=1", a_gnt); end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL single_busy0 got=%b exp=0", a_busy); end
        checks++; if (a_rdy !== 3'b010) begin failures++; $display("FAIL single_rdy0 got=%b exp=010", a_rdy); end
        tick();
        a_sop[1] = 1'b0; a_data[1] = 64'h2;
        #2;
        checks++; if (a_txd !== 64'h2 || a_txs !== 1'b0) begin failures++; $display("FAIL single_d1 got=%h/%b exp=2/0", a_txd, a_txs); end
        checks++; if (a_busy !== 1'b1 || a_gnt !== 2'd1) begin failures++; $display("FAIL single_busy1 got=%b/%0d exp=1/1", a_busy, a_gnt); end
        tick();
        a_eop[1] = 1'b1; a_data[1] = 64'h3;
        #2;
        checks++; if (a_txd !== 64'h3 || a_txe !== 1'b1) begin failures++; $display("FAIL single_d2 got=%h/%b exp=3/1", a_txd, a_txe); end
        checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL single_busy2 got=%b exp=1", a_busy); end
        tick();
        clr_a();
        #2;
        checks++; if (a_busy !== 1'b0 || a_txv !== 1'b0) begin failures++; $display("FAIL single_end got=%b/%b exp=0/0", a_busy, a_txv); end
        checks++; if (a_gnt !== 2'd1) begin failures++; $display("FAIL single_last got=%0d exp=1", a_gnt); end
    endtask

    task automatic test_rr_alternate;
        int cnt [2];
        int es;
        logic [63:0] ed;
        cnt[0] = 0; cnt[1] = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            for (int s = 0; s < 2; s++) begin
                a_valid[s] = 1'b1;
                a_sop[s]   = (cnt[s] % 2 == 0);
                a_eop[s]   = (cnt[s] % 2 == 1);
                a_data[s]  = 64'(s * 256 + (cnt[s] / 2) * 16 + cnt[s] % 2);
            end
            #2;
            es = (c / 2) % 2;
            ed = 64'(es * 256 + (c / 4) * 16 + c % 2);
            checks++; if (a_txd !== ed) begin failures++; $display("FAIL rr_data c=%0d got=%h exp=%h", c, a_txd, ed); end
            checks++; if (a_gnt !== 2'(es)) begin failures++; $display("FAIL rr_gnt c=%0d got=%0d exp=%0d", c, a_gnt, es); end
            checks++; if (a_txs !== (c % 2 == 0)) begin failures++; $display("FAIL rr_sop c=%0d got=%b", c, a_txs); end
            for (int s = 0; s < 2; s++) begin
                if (a_valid[s] && a_rdy[s]) cnt[s]++;
            end
        end
        tick();
        clr_a();
    endtask

    task automatic test_prio;
        int cnt [2];
        logic [63:0] ed;
        cnt[0] = 0; cnt[1] = 0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) tick();
            for (int s = 0; s < 2; s++) begin
                b_valid[s] = 1'b1;
                b_sop[s]   = (cnt[s] % 2 == 0);
                b_eop[s]   = (cnt[s] % 2 == 1);
                b_data[s]  = 64'(s * 256 + (cnt[s] / 2) * 16 + cnt[s] % 2);
            end
            #2;
            ed = 64'((c / 2) * 16 + c % 2);
            checks++; if (b_txd !== ed) begin failures++; $display("FAIL prio_data c=%0d got=%h exp=%h", c, b_txd, ed); end
            checks++; if (b_gnt !== 1'b0 || b_rdy[1] !== 1'b0) begin failures++; $display("FAIL prio_gnt c=%0d got=%0d/%b exp=0/0", c, b_gnt, b_rdy[1]); end
            for (int s = 0; s < 2; s++) begin
                if (b_valid[s] && b_rdy[s]) cnt[s]++;
            end
        end
        tick();
        clr_b();
    endtask

    task automatic test_lock_hold;
        tick();
        a_valid[1] = 1'b1; a_sop[1] = 1'b1; a_data[1] = 64'h11;
        #2;
        checks++; if (a_rdy !== 3'b010) begin failures++; $display("FAIL lock_rdy0 got=%b exp=010", a_rdy); end
        tick();
        a_sop[1] = 1'b0; a_data[1] = 64'h12;
        a_valid[0] = 1'b1; a_sop[0] = 1'b1; a_eop[0] = 1'b1; a_data[0] = 64'h21;
        #2;
        checks++; if (a_rdy !== 3'b010 || a_txd !== 64'h12) begin failures++; $display("FAIL lock_mid got=%b/%h exp=010/12", a_rdy, a_txd); end
        tick();
        a_eop[1] = 1'b1; a_data[1] = 64'h13;
        #2;
        checks++; if (a_rdy !== 3'b010 || a_txe !== 1'b1 || a_gnt !== 2'd1) begin failures++; $display("FAIL lock_eop got=%b/%b/%0d exp=010/1/1", a_rdy, a_txe, a_gnt); end
        tick();
        a_valid[1] = 1'b0; a_sop[1] = 1'b0; a_eop[1] = 1'b0;
        #2;
        checks++; if (a_txd !== 64'h21 || a_txs !== 1'b1) begin failures++; $display("FAIL lock_next got=%h/%b exp=21/1", a_txd, a_txs); end
        checks++; if (a_rdy !== 3'b001 || a_gnt !== 2'd0) begin failures++; $display("FAIL lock_next_rdy got=%b/%0d exp=001/0", a_rdy, a_gnt); end
        tick();
        clr_a();
    endtask

    task automatic test_stall;
        tick();
        a_valid[0] = 1'b1; a_sop[0] = 1'b1; a_data[0] = 64'h31;
        #2;
        checks++; if (a_txd !== 64'h31) begin failures++; $display("FAIL stall_b1 got=%h exp=31", a_txd); end
        tick();
        a_sop[0] = 1'b0; a_data[0] = 64'h32; a_txr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            #2;
            checks++; if (a_txv !== 1'b1 || a_txd !== 64'h32) begin failures++; $display("FAIL stall_hold i=%0d got=%b/%h exp=1/32", i, a_txv, a_txd); end
            checks++; if (a_rdy !== 3'b000 || a_gnt !== 2'd0 || a_busy !== 1'b1) begin failures++; $display("FAIL stall_ctl i=%0d got=%b/%0d/%b exp=000/0/1", i, a_rdy, a_gnt, a_busy); end
        end
        tick();
        a_txr = 1'b1;
        #2;
        checks++; if (a_rdy !== 3'b001 || a_txd !== 64'h32) begin failures++; $display("FAIL stall_resume got=%b/%h exp=001/32", a_rdy, a_txd); end
        tick();
        a_data[0] = 64'h33;
        #2;
        checks++; if (a_txd !== 64'h33) begin failures++; $display("FAIL stall_b3 got=%h exp=33", a_txd); end
        tick();
        a_data[0] = 64'h34; a_eop[0] = 1'b1;
        #2;
        checks++; if (a_txd !== 64'h34 || a_txe !== 1'b1) begin failures++; $display("FAIL stall_b4 got=%h/%b exp=34/1", a_txd, a_txe); end
        tick();
        clr_a();
        #2;
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL stall_end got=%b exp=0", a_busy); end
    endtask

    task automatic test_stray;
        tick();
        a_valid[2] = 1'b1; a_data[2] = 64'h99;
        #2;
        checks++; if (a_rdy !== 3'b100) begin failures++; $display("FAIL stray_rdy got=%b exp=100", a_rdy); end
        checks++; if (a_txv !== 1'b0 || a_txd !== 64'h0) begin failures++; $display("FAIL stray_fwd got=%b/%h exp=0/0", a_txv, a_txd); end
        checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL stray_err0 got=%b exp=0", a_err); end
        tick();
        clr_a();
        #2;
        checks++; if (a_err !== 1'b1) begin failures++; $display("FAIL stray_err1 got=%b exp=1", a_err); end
        tick();
        a_valid[1] = 1'b1; a_sop[1] = 1'b1; a_eop[1] = 1'b1; a_data[1] = 64'h55;
        #2;
        checks++; if (a_txd !== 64'h55) begin failures++; $display("FAIL stray_next got=%h exp=55", a_txd); end
        tick();
        clr_a();
        #2;
        checks++; if (a_err !== 1'b1) begin failures++; $display("FAIL stray_sticky got=%b exp=1", a_err); end
    endtask

    task automatic test_async_reset;
        tick();
        a_valid[1] = 1'b1; a_sop[1] = 1'b1; a_data[1] = 64'h41;
        #2;
        tick();
        a_sop[1] = 1'b0; a_data[1] = 64'h42;
        #2;
        checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL arst_pre got=%b exp=1", a_busy); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (a_txv !== 1'b0 || a_busy !== 1'b0) begin failures++; $display("FAIL arst_now got=%b/%b exp=0/0", a_txv, a_busy); end
        checks++; if (a_err !== 1'b0 || a_gnt !== 2'd2) begin failures++; $display("FAIL arst_regs got=%b/%0d exp=0/2", a_err, a_gnt); end
        clr_a();
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        a_valid[0] = 1'b1; a_sop[0] = 1'b1; a_eop[0] = 1'b1; a_data[0] = 64'h51;
        a_valid[1] = 1'b1; a_sop[1] = 1'b1; a_eop[1] = 1'b1; a_data[1] = 64'h61;
        #2;
        checks++; if (a_gnt !== 2'd0 || a_txd !== 64'h51) begin failures++; $display("FAIL arst_first got=%0d/%h exp=0/51", a_gnt, a_txd); end
        tick();
        clr_a();
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_alternate();
        test_prio();
        test_lock_hold();
        test_stall();
        test_stray();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tlp_tx_arb.md
# tlp_tx_arb

Packet-atomic arbiter sharing the single 64-bit PCIe TX Avalon-ST channel between several TLP sources (e.g. read-completion generator, DMA write engine, MSI generator). Selects one source per TLP, holds the grant from SOP through EOP so TLPs are never interleaved, and forwards beats combinationally with zero added latency. Sits between the TLP-producing engines and the PCIe hard-IP TX port in the `pcieClk_in` domain.

## Interface

- `NUM_SRC`, 2: number of TLP sources; legal range 2..4.
- `PRIO_SRC0`, 0: 1 = source 0 has strict priority at every arbitration point; 0 = pure round-robin.
- `IDX_BITS`, `$clog2(NUM_SRC)`: width of grant index (derived; do not override).

- `pcieClk_in`  in  1  125MHz core clock from the PCIe PLL.
- `pcieRstN_in`  in  1  reset; asynchronous assert, active-low.
- `srcData_in`  in  `[NUM_SRC-1:0][63:0]`  per-source TLP beat.
- `srcValid_in`  in  `NUM_SRC`  per-source beat valid.
- `srcReady_out`  out  `NUM_SRC`  per-source beat accepted when valid&ready.
- `srcSOP_in`  in  `NUM_SRC`  per-source first beat of TLP.
- `srcEOP_in`  in  `NUM_SRC`  per-source last beat of TLP.
- `txData_out`  out  64  beat to PCIe IP.
- `txValid_out`  out  1  beat valid.
- `txReady_in`  in  1  PCIe IP accepts beat.
- `txSOP_out`  out  1  first beat.
- `txEOP_out`  out  1  last beat.
- `grant_out`  out  `IDX_BITS`  index of source owning (or last owning) the channel.
- `busy_out`  out  1  high while a multi-beat TLP is in flight (state LOCKED).
- `protoErr_out`  out  1  sticky protocol-violation flag; cleared only by reset.

## Operation

- States: IDLE, LOCKED. Registers: `state`, `owner` (IDX_BITS), `last` (round-robin pointer, IDX_BITS), `protoErr`.
- Request in IDLE: source i requests iff `srcValid_in[i] && srcSOP_in[i]`.
- Selection in IDLE: if `PRIO_SRC0` and source 0 requests, pick 0; else first requester scanning `last+1, last+2, …` modulo `NUM_SRC` (wrap from NUM_SRC-1 to 0).
- Forwarding: selected source's data/valid/SOP/EOP drive `tx*_out` combinationally; `srcReady_out[sel] = txReady_in`; all other readies 0 (except stray drain below).
- On accepted SOP beat (valid&ready) in IDLE: `last <= sel`; if beat also has EOP (single-beat TLP) stay IDLE, else `owner <= sel`, go LOCKED.
- LOCKED: `sel = owner`, no arbitration; other sources' requests ignored. Accepted beat with EOP -> IDLE.
- Stray beats: in IDLE, any source with valid && !SOP gets `srcReady_out=1`, beat discarded (not forwarded), `protoErr <= 1`. In LOCKED, owner beat with SOP set is forwarded unchanged and sets `protoErr`.
- No requester in IDLE: `txValid_out=0`, `txSOP_out=0`, `txEOP_out=0`, `txData_out=0`.
- `grant_out = owner` in LOCKED, `sel` in IDLE when a request exists, else `last`.
- Reset mid-TLP: state forced IDLE, lock dropped; truncation accepted because PCIe core resets concurrently.

## Timing

- Reset values: `state=IDLE`, `owner=0`, `last=NUM_SRC-1` (so source 0 wins first round-robin), `protoErr=0`; hence all `srcReady_out=0` unless txReady_in/stray, `txValid_out=0`, `txSOP_out=0`, `txEOP_out=0`, `txData_out=0`, `busy_out=0`, `grant_out=NUM_SRC-1`.
- Latency 0: first beat appears on `tx*_out` the same cycle the source presents it, if selected.
- Back-to-back: EOP accepted in cycle N -> next TLP (any source) may present SOP in N+1; no bubble.
- `txReady_in` low: all outputs hold source-driven values; grant and `last` unchanged; txValid never deasserted by the arbiter mid-TLP (owner must keep valid high; owner gaps pass through as-is).
- Selection uses only registered `last`/`state` plus current inputs; no combinational path from `txReady_in` into selection.

## Test plan

- Single source 1, 3-beat TLP (SOP beat 64'h1, mid 64'h2, EOP 64'h3), txReady=1: tx sees 1,2,3 in 3 consecutive cycles, SOP on first, EOP on third, busy_out high cycles 1-2, grant_out=1.
- Sources 0 and 1 both present 2-beat TLPs continuously, PRIO_SRC0=0: order 0,1,0,1…, no bubbles, no interleaving; with PRIO_SRC0=1 source 0 wins every arbitration.
- Source 1 mid-TLP, source 0 raises SOP: source 0 ready stays 0 until source 1 EOP accepted; source 0 SOP forwarded next cycle.
- txReady_in low 5 cycles during beat 2 of 4: beat 2 held, srcReady low, grant unchanged; completes after ready returns.
- Source 2 asserts valid without SOP in IDLE (NUM_SRC=3): beat drained, not forwarded, protoErr_out=1 and stays 1 until pcieRstN_in low.
- Assert pcieRstN_in low mid-TLP asynchronously: txValid_out=0, busy_out=0 immediately; after release, source 0 wins first arbitration.
